// File: rtl/rwt_adc_capture_pkg.sv
// Shared types and helpers for the ADC capture sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rwt_adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic TRIG_IMMEDIATE = 1'b0;
  localparam logic TRIG_EXTERNAL  = 1'b1;

  // Widest lane the masking helper handles; lanes are zero-extended into it.
  localparam int LANE_MAX_W = 64;

  // Pass a lane through when it is both enabled by the ADC and selected by software.
  function automatic logic [LANE_MAX_W-1:0] mask_lane(
    input logic [LANE_MAX_W-1:0] lane,
    input logic                  keep
  );
    return keep ? lane : '0;
  endfunction

endpackage

// File: rtl/rwt_adc_trig_detect.sv
// External trigger synchroniser with rising-edge pulse output.
// Latency: SYNC_STAGES cycles from trig_in rise to a 1-cycle trig_rise pulse.
// Backpressure: none; edges arriving when nobody listens are simply lost.
module rwt_adc_trig_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic trig_in,
  output logic trig_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign trig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rwt_adc_capture_ctrl.sv
// ADC capture sequencer: arm, trigger, capture N masked beats, emit AXI-Stream packet.
// Latency: 1 cycle from a qualified adc_valid[0] beat to m_axis_tvalid.
// Backpressure: single output register; beats arriving while it is full and tready=0 are dropped and flagged.
module rwt_adc_capture_ctrl
  import rwt_adc_capture_pkg::*;
#(
  parameter int NUM_CHANNELS     = 4,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int COUNT_WIDTH      = 32,
  parameter int TRIG_SYNC_STAGES = 2
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 cfg_start,
  input  logic                                 cfg_stop,
  input  logic [COUNT_WIDTH-1:0]               cfg_length,
  input  logic [NUM_CHANNELS-1:0]              cfg_chan_mask,
  input  logic                                 cfg_cyclic,
  input  logic                                 cfg_trig_src,
  input  logic                                 trig_in,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] adc_data,
  input  logic [NUM_CHANNELS-1:0]              adc_enable,
  input  logic [NUM_CHANNELS-1:0]              adc_valid,
  output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 status_busy,
  output logic                                 status_done,
  output logic                                 status_overflow,
  output logic [COUNT_WIDTH-1:0]               sample_count
);

  localparam int DW = NUM_CHANNELS * SAMPLE_WIDTH;

  state_t state_q, state_nxt;

  logic [COUNT_WIDTH-1:0]  len_q;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic                    cyclic_q;
  logic                    trig_src_q;
  logic                    stop_seen_q;

  logic                    trig_rise;
  logic                    start_acc;
  logic                    beat;
  logic                    last_beat;
  logic                    load;
  logic                    drop;
  logic                    hs;
  logic                    flush_done;
  logic                    enter_capture;
  logic [COUNT_WIDTH-1:0]  count_inc;
  logic [DW-1:0]           masked;

  // Only lane 0's strobe qualifies a beat; the other strobes are redundant copies.
  logic unused_valid;
  assign unused_valid = ^adc_valid[NUM_CHANNELS-1:1];

  rwt_adc_trig_detect #(
    .SYNC_STAGES(TRIG_SYNC_STAGES)
  ) u_trig (
    .clk      (clk),
    .rstn     (rstn),
    .trig_in  (trig_in),
    .trig_rise(trig_rise)
  );

  // A stop in the same cycle as a start wins, so the start is not accepted.
  assign start_acc  = (state_q == IDLE) & cfg_start & ~cfg_stop;
  assign beat       = (state_q == CAPTURE) & adc_valid[0];
  assign count_inc  = (&sample_count) ? sample_count : sample_count + COUNT_WIDTH'(1);
  // Length-terminated packet, or the first beat after a stop in continuous/any mode.
  assign last_beat  = beat & (((len_q != '0) & (count_inc == len_q)) | stop_seen_q);
  assign hs         = m_axis_tvalid & m_axis_tready;
  assign load       = beat & (~m_axis_tvalid | m_axis_tready);
  assign drop       = beat & m_axis_tvalid & ~m_axis_tready;
  assign flush_done = (state_q == FLUSH) & hs & m_axis_tlast;
  assign enter_capture = (state_q == ARMED) & (state_nxt == CAPTURE);
  assign status_busy   = (state_q != IDLE);

  // Zero lanes that the ADC has disabled or software has masked off.
  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      masked[SAMPLE_WIDTH*i +: SAMPLE_WIDTH] = SAMPLE_WIDTH'(mask_lane(
        LANE_MAX_W'(adc_data[SAMPLE_WIDTH*i +: SAMPLE_WIDTH]),
        adc_enable[i] & mask_q[i]));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_acc) state_nxt = ARMED;
      end
      ARMED: begin
        if (cfg_stop)                                           state_nxt = IDLE;
        else if ((trig_src_q == TRIG_IMMEDIATE) || trig_rise)   state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (flush_done) begin
          state_nxt = (cyclic_q & ~stop_seen_q & ~cfg_stop) ? ARMED : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration snapshot taken on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q      <= '0;
      mask_q     <= '0;
      cyclic_q   <= 1'b0;
      trig_src_q <= TRIG_IMMEDIATE;
    end else if (start_acc) begin
      len_q      <= cfg_length;
      mask_q     <= cfg_chan_mask;
      cyclic_q   <= cfg_cyclic;
      trig_src_q <= cfg_trig_src;
    end
  end

  // Remember a stop seen mid-packet: it ends the packet and suppresses cyclic re-arm.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stop_seen_q <= 1'b0;
    end else if (start_acc || state_q == ARMED) begin
      stop_seen_q <= 1'b0;
    end else if (cfg_stop && (state_q == CAPTURE || state_q == FLUSH)) begin
      stop_seen_q <= 1'b1;
    end
  end

  // Beat counter: cleared on entry to capture, saturating, counts dropped beats too.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              sample_count <= '0;
    else if (enter_capture) sample_count <= '0;
    else if (beat)          sample_count <= count_inc;
  end

  // Sticky overflow, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          status_overflow <= 1'b0;
    else if (start_acc) status_overflow <= 1'b0;
    else if (drop)      status_overflow <= 1'b1;
  end

  // Output register: reload in the handshake cycle; a dropped last beat tags the held one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= masked;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= last_beat;
    end else begin
      if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
      if (drop && last_beat) m_axis_tlast <= 1'b1;
    end
  end

  // Done pulses the cycle after the tlast beat leaves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) status_done <= 1'b0;
    else       status_done <= flush_done;
  end

endmodule

// File: tb/tb_rwt_adc_capture_ctrl.sv
// Directed bench for the ADC capture sequencer: lane-mask table plus hand-built sequences.
// Latency: checks 1-cycle beat latency and trigger synchroniser delay.
// Backpressure: exercises tready=0 overflow, held-tlast and stop-in-flush paths.
module tb_rwt_adc_capture_ctrl;

  localparam int NCH = 4;
  localparam int SW  = 16;
  localparam int CW  = 32;
  localparam int NS  = 2;

  logic              clk;
  logic              rstn;
  logic              cfg_start;
  logic              cfg_stop;
  logic [CW-1:0]     cfg_length;
  logic [NCH-1:0]    cfg_chan_mask;
  logic              cfg_cyclic;
  logic              cfg_trig_src;
  logic              trig_in;
  logic [NCH*SW-1:0] adc_data;
  logic [NCH-1:0]    adc_enable;
  logic [NCH-1:0]    adc_valid;
  logic [NCH*SW-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              status_busy;
  logic              status_done;
  logic              status_overflow;
  logic [CW-1:0]     sample_count;

  rwt_adc_capture_ctrl #(
    .NUM_CHANNELS(NCH), .SAMPLE_WIDTH(SW), .COUNT_WIDTH(CW), .TRIG_SYNC_STAGES(NS)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_length(cfg_length),
    .cfg_chan_mask(cfg_chan_mask), .cfg_cyclic(cfg_cyclic), .cfg_trig_src(cfg_trig_src),
    .trig_in(trig_in), .adc_data(adc_data), .adc_enable(adc_enable), .adc_valid(adc_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .status_busy(status_busy), .status_done(status_done),
    .status_overflow(status_overflow), .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    en;
    logic [NCH*SW-1:0] data;
    logic [NCH*SW-1:0] exp;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int seq    = 0;
  int done_cnt;
  logic              fixed_mode = 1'b0;
  logic [NCH*SW-1:0] fixed_data = '0;
  logic [NCH*SW-1:0] hs_dat[$];
  logic              hs_last[$];

  // Lane i carries {i, low 12 bits of the cycle stamp}.
  function automatic logic [NCH*SW-1:0] pat(input int s);
    logic [NCH*SW-1:0] r;
    logic [31:0]       sv;
    sv = s;
    for (int i = 0; i < NCH; i++) r[SW*i +: SW] = {4'(i), sv[11:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge: record what the coming posedge will see, then advance.
  task automatic step();
    if (m_axis_tvalid && m_axis_tready) begin
      hs_dat.push_back(m_axis_tdata);
      hs_last.push_back(m_axis_tlast);
    end
    if (status_done) done_cnt++;
    @(negedge clk);
    seq++;
    adc_data = fixed_mode ? fixed_data : pat(seq);
  endtask

  task automatic clr_mon();
    hs_dat.delete();
    hs_last.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [CW-1:0] len, input logic [NCH-1:0] mask,
                          input logic cyc, input logic src);
    cfg_length    = len;
    cfg_chan_mask = mask;
    cfg_cyclic    = cyc;
    cfg_trig_src  = src;
    cfg_start     = 1'b1;
    step();
    cfg_start     = 1'b0;
  endtask

  int s0;
  int n;
  int lasts;

  initial begin
    vecs[0] = '{4'b0101, 4'hF,    64'h4444_3333_2222_1111, 64'h0000_3333_0000_1111};
    vecs[1] = '{4'hF,    4'b1010, 64'h4444_3333_2222_1111, 64'h4444_0000_2222_0000};
    vecs[2] = '{4'h0,    4'hF,    64'h4444_3333_2222_1111, 64'h0000_0000_0000_0000};
    vecs[3] = '{4'hF,    4'hF,    64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[4] = '{4'b1100, 4'b0110, 64'h4444_3333_2222_1111, 64'h0000_3333_0000_0000};

    rstn = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_length = '0;
    cfg_chan_mask = '0; cfg_cyclic = 1'b0; cfg_trig_src = 1'b0; trig_in = 1'b0;
    adc_data = '0; adc_enable = 4'hF; adc_valid = '0; m_axis_tready = 1'b1;
    clr_mon();
    repeat (3) @(negedge clk);
    chk("reset_flags", 64'({m_axis_tvalid, m_axis_tlast, status_busy, status_done, status_overflow}), 64'd0);
    chk("reset_tdata", m_axis_tdata, 64'd0);
    chk("reset_count", 64'(sample_count), 64'd0);
    rstn = 1'b1;
    step();

    // Basic 8-beat single-shot packet.
    adc_valid = 4'hF;
    clr_mon();
    s0 = seq;
    do_start(8, 4'hF, 1'b0, 1'b0);
    repeat (19) step();
    chk("t1_beats", 64'(hs_dat.size()), 64'd8);
    if (hs_dat.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("t1_dat%0d", k), hs_dat[k], pat(s0 + 2 + k));
        chk($sformatf("t1_last%0d", k), 64'(hs_last[k]), 64'(k == 7));
      end
    end
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_count", 64'(sample_count), 64'd8);
    chk("t1_busy", 64'(status_busy), 64'd0);

    // Lane masking table, one single-beat packet per vector.
    fixed_mode = 1'b1;
    for (int v = 0; v < 5; v++) begin
      fixed_data = vecs[v].data;
      adc_data   = vecs[v].data;
      adc_enable = vecs[v].en;
      clr_mon();
      do_start(1, vecs[v].mask, 1'b0, 1'b0);
      repeat (6) step();
      chk($sformatf("mask_dat%0d", v), (hs_dat.size() == 1) ? hs_dat[0] : 64'hx, vecs[v].exp);
      chk($sformatf("mask_last%0d", v), (hs_last.size() == 1) ? 64'(hs_last[0]) : 64'hx, 64'd1);
    end
    fixed_mode = 1'b0;
    adc_enable = 4'hF;

    // Backpressure: length 4, tready low, beats 2-4 dropped.
    m_axis_tready = 1'b0;
    clr_mon();
    s0 = seq;
    do_start(4, 4'hF, 1'b0, 1'b0);
    repeat (7) step();
    chk("ovf_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("ovf_tlast", 64'(m_axis_tlast), 64'd1);
    chk("ovf_flag", 64'(status_overflow), 64'd1);
    chk("ovf_held", m_axis_tdata, pat(s0 + 2));
    chk("ovf_count", 64'(sample_count), 64'd4);
    chk("ovf_nodone", 64'(done_cnt), 64'd0);
    m_axis_tready = 1'b1;
    repeat (3) step();
    chk("ovf_beats", 64'(hs_dat.size()), 64'd1);
    chk("ovf_done", 64'(done_cnt), 64'd1);
    chk("ovf_idle", 64'(status_busy), 64'd0);
    chk("ovf_sticky", 64'(status_overflow), 64'd1);

    // Continuous capture ended by stop after 5 beats.
    clr_mon();
    do_start(0, 4'hF, 1'b0, 1'b0);
    chk("ovf_cleared", 64'(status_overflow), 64'd0);
    repeat (6) step();
    adc_valid = '0;
    cfg_stop  = 1'b1;
    step();
    cfg_stop  = 1'b0;
    adc_valid = 4'hF;
    repeat (10) step();
    chk("stop_beats", 64'(hs_dat.size()), 64'd6);
    if (hs_last.size() == 6) begin
      chk("stop_last5", 64'(hs_last[5]), 64'd1);
      chk("stop_last4", 64'(hs_last[4]), 64'd0);
    end
    chk("stop_done", 64'(done_cnt), 64'd1);
    chk("stop_idle", 64'(status_busy), 64'd0);
    chk("stop_count", 64'(sample_count), 64'd6);

    // Cyclic 2-beat packets, then stop while the last beat is held.
    clr_mon();
    do_start(2, 4'hF, 1'b1, 1'b0);
    repeat (20) step();
    lasts = 0;
    for (int k = 0; k < hs_last.size(); k++) begin
      if (hs_last[k]) lasts++;
      if ((k % 2) == 1) chk($sformatf("cyc_last%0d", k), 64'(hs_last[k]), 64'd1);
    end
    chk("cyc_pairs", 64'(hs_dat.size()), 64'(2 * lasts));
    chk("cyc_many", 64'(done_cnt >= 3), 64'd1);
    chk("cyc_busy", 64'(status_busy), 64'd1);
    m_axis_tready = 1'b0;
    n = 0;
    while (!(m_axis_tvalid && m_axis_tlast) && n < 20) begin
      step();
      n++;
    end
    chk("cyc_tlast_held", 64'(m_axis_tvalid && m_axis_tlast), 64'd1);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    m_axis_tready = 1'b1;
    clr_mon();
    repeat (12) step();
    chk("cyc_stop_beats", 64'(hs_dat.size()), 64'd1);
    chk("cyc_stop_done", 64'(done_cnt), 64'd1);
    chk("cyc_stop_idle", 64'(status_busy), 64'd0);

    // Stop in IDLE does nothing; stop in ARMED returns to IDLE silently.
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk("idle_stop", 64'(status_busy), 64'd0);
    clr_mon();
    do_start(2, 4'hF, 1'b0, 1'b1);
    repeat (3) step();
    chk("armed_busy", 64'(status_busy), 64'd1);
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    repeat (3) step();
    chk("armed_stop", 64'({status_busy, m_axis_tvalid}), 64'd0);
    chk("armed_nodone", 64'(done_cnt + hs_dat.size()), 64'd0);

    // External trigger: nothing for 100 cycles, then an edge starts capture.
    clr_mon();
    do_start(2, 4'hF, 1'b0, 1'b1);
    repeat (100) step();
    chk("trig_wait_beats", 64'(hs_dat.size()), 64'd0);
    chk("trig_wait_busy", 64'(status_busy), 64'd1);
    trig_in = 1'b1;
    n = 0;
    while (!m_axis_tvalid && n < 20) begin
      step();
      n++;
    end
    chk("trig_latency", 64'(n >= 3 && n <= NS + 3), 64'd1);
    trig_in = 1'b0;
    repeat (10) step();
    chk("trig_beats", 64'(hs_dat.size()), 64'd2);
    chk("trig_done", 64'(done_cnt), 64'd1);

    // Asynchronous reset in the middle of a continuous capture.
    clr_mon();
    do_start(0, 4'hF, 1'b0, 1'b0);
    repeat (6) step();
    chk("rst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_flags", 64'({m_axis_tvalid, m_axis_tlast, status_busy, status_done, status_overflow}), 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) step();
    chk("rst_stays_idle", 64'({status_busy, m_axis_tvalid}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
